pcie_tlp_class_router: RTL and testbench

//  - N-way packet router for TLPs arriving on a single AXIS stream from the datalink layer.
//  - Decodes Fmt/Type from header DW0 on the head beat and classifies the TLP as CFG, IO, MEM, CPL or MSG.
//  - Steers the whole packet to one of NUM_PORTS AXIS outputs via a parameterised class->port map.
//  - Sits between the DLLP-to-TLP stage and the config space / DMA / completion consumers.

---
 rtl/pcie_tlp_class_router_if.sv | 18 +
 rtl/pcie_tlp_class_router.sv | 229 ++++++++++++++++++++++
 tb/tb_pcie_tlp_class_router.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tlp_class_router_if.sv
// AXI4-Stream bundle for pcie_tlp_class_router; LANES parallel streams are packed
// side by side (lane p at [p*DATA_WIDTH +: DATA_WIDTH] and so on).
interface pcie_tlp_class_router_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int LANES      = 1
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*KEEP_WIDTH-1:0] tkeep;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tlast;
  logic [LANES*USER_WIDTH-1:0] tuser;
  logic [LANES-1:0]            tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/pcie_tlp_class_router.sv
// TLP class router: input skid -> Fmt/Type classifier FSM -> one output skid per port.
// Defining PCIE_ROUTER_STATS_EN adds per-port forwarded-TLP counters on stat_cnt_o.
module pcie_tlp_class_router #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int NUM_PORTS  = 3,
  parameter int CFG_PORT   = 0,
  parameter int IO_PORT    = 0,
  parameter int MEM_PORT   = 2,
  parameter int CPL_PORT   = 1,
  parameter int MSG_PORT   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  pcie_tlp_class_router_if.slave  s_axis,
  pcie_tlp_class_router_if.master m_axis,
  output logic                    drop_o
`ifdef PCIE_ROUTER_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0] stat_cnt_o
`endif
);

  localparam int BEAT_W   = DATA_WIDTH + 1 + KEEP_WIDTH + USER_WIDTH;
  localparam int LAST_B   = DATA_WIDTH;
  localparam int KEEP_LSB = DATA_WIDTH + 1;
  localparam int USER_LSB = DATA_WIDTH + 1 + KEEP_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Any class mapped outside 0..NUM_PORTS-1 collapses onto the single drop code.
  localparam logic [3:0] DROP_SEL = 4'hF;
  localparam logic [3:0] CFG_SEL = (CFG_PORT >= 0 && CFG_PORT < NUM_PORTS) ? 4'(CFG_PORT) : DROP_SEL;
  localparam logic [3:0] IO_SEL  = (IO_PORT  >= 0 && IO_PORT  < NUM_PORTS) ? 4'(IO_PORT)  : DROP_SEL;
  localparam logic [3:0] MEM_SEL = (MEM_PORT >= 0 && MEM_PORT < NUM_PORTS) ? 4'(MEM_PORT) : DROP_SEL;
  localparam logic [3:0] CPL_SEL = (CPL_PORT >= 0 && CPL_PORT < NUM_PORTS) ? 4'(CPL_PORT) : DROP_SEL;
  localparam logic [3:0] MSG_SEL = (MSG_PORT >= 0 && MSG_PORT < NUM_PORTS) ? 4'(MSG_PORT) : DROP_SEL;

  // Fmt is irrelevant to the class; only the 5-bit Type field is decoded.
  function automatic logic [3:0] classify(input logic [4:0] tlp_type);
    logic [3:0] sel;
    sel = DROP_SEL;
    if (tlp_type[4:1] == 4'b0000)                             sel = MEM_SEL;
    else if (tlp_type == 5'b00010)                            sel = IO_SEL;
    else if (tlp_type[4:1] == 4'b0010 || tlp_type == 5'b11011) sel = CFG_SEL;
    else if (tlp_type[4:1] == 4'b0101)                        sel = CPL_SEL;
    else if (tlp_type[4:3] == 2'b10)                          sel = MSG_SEL;
    return sel;
  endfunction

  logic [BEAT_W-1:0]    s_beat;
  logic                 s_fire;
  logic                 rdy_en_q, rdy_en_d;
  logic                 vld_p0_q, vld_p0_d, skid_vld_p0_q, skid_vld_p0_d;
  logic [BEAT_W-1:0]    beat_p0_q, beat_p0_d, skid_beat_p0_q, skid_beat_p0_d;
  logic [1:0]           state_q, state_d;
  logic [3:0]           dest_q, dest_d, head_sel;
  logic                 head_drop, last_p0, pop;
  logic                 drop_q, drop_d;
  logic [NUM_PORTS-1:0] push_vld, oready;
  logic [NUM_PORTS-1:0] vld_p1_q, vld_p1_d, skid_vld_p1_q, skid_vld_p1_d;
  logic [BEAT_W-1:0]    beat_p1_q [NUM_PORTS];
  logic [BEAT_W-1:0]    beat_p1_d [NUM_PORTS];
  logic [BEAT_W-1:0]    skid_beat_p1_q [NUM_PORTS];
  logic [BEAT_W-1:0]    skid_beat_p1_d [NUM_PORTS];

  assign s_beat        = {s_axis.tuser, s_axis.tkeep, s_axis.tlast, s_axis.tdata};
  assign s_axis.tready = rdy_en_q && !skid_vld_p0_q;
  assign s_fire        = s_axis.tvalid[0] && s_axis.tready[0];
  assign drop_o        = drop_q;

  // ---- p0: input skid; ready is registered so it never waits on the router ----
  always_comb begin
    rdy_en_d       = 1'b1;
    vld_p0_d       = vld_p0_q;
    skid_vld_p0_d  = skid_vld_p0_q;
    beat_p0_d      = beat_p0_q;
    skid_beat_p0_d = skid_beat_p0_q;
    if (!vld_p0_q || pop) begin
      if (skid_vld_p0_q) begin
        beat_p0_d     = skid_beat_p0_q;
        vld_p0_d      = 1'b1;
        skid_vld_p0_d = 1'b0;
      end else begin
        beat_p0_d = s_beat;
        vld_p0_d  = s_fire;
      end
    end else if (s_fire) begin
      skid_vld_p0_d  = 1'b1;
      skid_beat_p0_d = s_beat;
    end
  end

  // ---- router FSM: steer p0 beat into exactly one output skid, or discard ----
  assign head_sel  = classify(beat_p0_q[4:0]);
  assign head_drop = (head_sel == DROP_SEL);
  assign last_p0   = beat_p0_q[LAST_B];
  assign oready    = ~skid_vld_p1_q;

  always_comb begin
    pop      = 1'b0;
    push_vld = '0;
    state_d  = state_q;
    dest_d   = dest_q;
    drop_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vld_p0_q) begin
          if (head_drop) begin
            pop    = 1'b1;
            drop_d = 1'b1;
            if (!last_p0) state_d = ST_DROP;
          end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (head_sel == 4'(p)) begin
                push_vld[p] = 1'b1;
                pop         = oready[p];
              end
            end
            if (pop && !last_p0) begin
              state_d = ST_FWD;
              dest_d  = head_sel;
            end
          end
        end
      end
      ST_FWD: begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (dest_q == 4'(p)) begin
            push_vld[p] = vld_p0_q;
            pop         = vld_p0_q && oready[p];
          end
        end
        if (pop && last_p0) state_d = ST_IDLE;
      end
      ST_DROP: begin
        pop = vld_p0_q;
        if (pop && last_p0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- p1: per-port output skid; holds data stable while tvalid && !tready ----
  always_comb begin
    vld_p1_d       = vld_p1_q;
    skid_vld_p1_d  = skid_vld_p1_q;
    beat_p1_d      = beat_p1_q;
    skid_beat_p1_d = skid_beat_p1_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!vld_p1_q[p] || m_axis.tready[p]) begin
        if (skid_vld_p1_q[p]) begin
          beat_p1_d[p]     = skid_beat_p1_q[p];
          vld_p1_d[p]      = 1'b1;
          skid_vld_p1_d[p] = 1'b0;
        end else begin
          beat_p1_d[p] = beat_p0_q;
          vld_p1_d[p]  = push_vld[p];
        end
      end else if (push_vld[p] && oready[p]) begin
        skid_vld_p1_d[p]  = 1'b1;
        skid_beat_p1_d[p] = beat_p0_q;
      end
    end
  end

  assign m_axis.tvalid = vld_p1_q;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    assign m_axis.tdata[g*DATA_WIDTH +: DATA_WIDTH] = beat_p1_q[g][DATA_WIDTH-1:0];
    assign m_axis.tlast[g]                          = beat_p1_q[g][LAST_B];
    assign m_axis.tkeep[g*KEEP_WIDTH +: KEEP_WIDTH] = beat_p1_q[g][KEEP_LSB +: KEEP_WIDTH];
    assign m_axis.tuser[g*USER_WIDTH +: USER_WIDTH] = beat_p1_q[g][USER_LSB +: USER_WIDTH];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdy_en_q      <= 1'b0;
      vld_p0_q      <= 1'b0;
      skid_vld_p0_q <= 1'b0;
      state_q       <= ST_IDLE;
      dest_q        <= '0;
      drop_q        <= 1'b0;
      vld_p1_q      <= '0;
      skid_vld_p1_q <= '0;
    end else begin
      rdy_en_q      <= rdy_en_d;
      vld_p0_q      <= vld_p0_d;
      skid_vld_p0_q <= skid_vld_p0_d;
      state_q       <= state_d;
      dest_q        <= dest_d;
      drop_q        <= drop_d;
      vld_p1_q      <= vld_p1_d;
      skid_vld_p1_q <= skid_vld_p1_d;
    end
  end

  always_ff @(posedge clk_i) begin
    beat_p0_q      <= beat_p0_d;
    skid_beat_p0_q <= skid_beat_p0_d;
    beat_p1_q      <= beat_p1_d;
    skid_beat_p1_q <= skid_beat_p1_d;
  end

`ifdef PCIE_ROUTER_STATS_EN
  logic [31:0] cnt_q [NUM_PORTS];
  logic [31:0] cnt_d [NUM_PORTS];

  // A TLP counts once its tlast beat leaves the router toward its port.
  always_comb begin
    cnt_d = cnt_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pop && last_p0 && push_vld[p]) cnt_d[p] = cnt_q[p] + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '{default: '0};
    else       cnt_q <= cnt_d;
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
    assign stat_cnt_o[g*32 +: 32] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_pcie_tlp_class_router.sv
// Bench for pcie_tlp_class_router: directed scenarios plus randomized traffic
// scored against a per-port expected-beat queue model.
module tb_pcie_tlp_class_router;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 1;
  localparam int NP = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drop;
  always #5 clk = ~clk;

  pcie_tlp_class_router_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .LANES(1))  s_if ();
  pcie_tlp_class_router_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .LANES(NP)) m_if ();

`ifdef PCIE_ROUTER_STATS_EN
  logic [NP*32-1:0] stat_cnt;
`endif

  pcie_tlp_class_router #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .NUM_PORTS(NP),
    .CFG_PORT(0), .IO_PORT(0), .MEM_PORT(2), .CPL_PORT(1), .MSG_PORT(0)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .s_axis (s_if),
    .m_axis (m_if),
    .drop_o (drop)
`ifdef PCIE_ROUTER_STATS_EN
    ,
    .stat_cnt_o (stat_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;

  // Reference model state
  beat_t exp_q [NP][$];
  int    pop_cyc_q [NP][$];
  int    acc_cyc_q [$];
  int    pop_cnt [NP];
  int    vld_cyc [NP];
  int    exp_fwd_pkts [NP];
  int    drop_seen = 0;
  int    drop_exp = 0;
  int    in_dest = -1;
  bit    in_body = 1'b0;
  int    last_head_cyc = 0;
  logic [NP-1:0] stall_prev = '0;
  beat_t prev_beat [NP];

  // Destination port of a TLP from its first byte; -1 means dropped.
  function automatic int exp_port(input logic [7:0] b0);
    int t;
    t = int'(b0) % 32;
    if (t < 2) return 2;
    if (t == 2) return 0;
    if (t == 4 || t == 5 || t == 27) return 0;
    if (t == 10 || t == 11) return 1;
    if (t >= 16 && t < 24) return 0;
    return -1;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor and scoreboard: sampled mid-cycle, evaluating the handshakes of the next edge.
  initial begin : monitor
    beat_t got, e;
    for (int p = 0; p < NP; p++) begin
      pop_cnt[p] = 0; vld_cyc[p] = 0; exp_fwd_pkts[p] = 0; prev_beat[p] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        for (int p = 0; p < NP; p++) begin
          exp_q[p].delete();
          exp_fwd_pkts[p] = 0;
        end
        in_body    = 1'b0;
        stall_prev = '0;
      end else begin
        if (s_if.tvalid[0] && s_if.tready[0]) begin
          acc_cyc_q.push_back(cyc);
          if (!in_body) begin
            in_dest       = exp_port(s_if.tdata[7:0]);
            last_head_cyc = cyc;
            if (in_dest < 0) drop_exp++;
          end
          if (in_dest >= 0) begin
            e.d = s_if.tdata; e.k = s_if.tkeep; e.l = s_if.tlast[0]; e.u = s_if.tuser;
            exp_q[in_dest].push_back(e);
            if (s_if.tlast[0]) exp_fwd_pkts[in_dest]++;
          end
          in_body = !s_if.tlast[0];
        end
        if (drop) drop_seen++;
        for (int p = 0; p < NP; p++) begin
          got.d = m_if.tdata[p*DW +: DW];
          got.k = m_if.tkeep[p*KW +: KW];
          got.l = m_if.tlast[p];
          got.u = m_if.tuser[p*UW +: UW];
          if (stall_prev[p]) begin
            checks++;
            if (!m_if.tvalid[p] || got !== prev_beat[p]) begin
              errors++;
              $display("FAIL stable port%0d vld=%0b data=%h required vld=1 data=%h", p, m_if.tvalid[p], got, prev_beat[p]);
            end
          end
          if (m_if.tvalid[p]) begin
            vld_cyc[p]++;
            if (m_if.tready[p]) begin
              checks++;
              if (exp_q[p].size() == 0) begin
                errors++;
                $display("FAIL beat port%0d got %h required none", p, got);
              end else begin
                e = exp_q[p].pop_front();
                if (got !== e) begin
                  errors++;
                  $display("FAIL beat port%0d got %h required %h", p, got, e);
                end
              end
              pop_cnt[p]++;
              pop_cyc_q[p].push_back(cyc);
            end
          end
          stall_prev[p] = m_if.tvalid[p] && !m_if.tready[p];
          prev_beat[p]  = got;
        end
      end
    end
  end

  // Random per-port ready when enabled
  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) m_if.tready = NP'($urandom);
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [UW-1:0] u, input logic l);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tkeep = k; s_if.tuser = u; s_if.tlast = l;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = s_if.tready[0];
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout got tready=0 required 1");
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] head, input int len, input bit gaps);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(3) == 0) begin @(posedge clk); #1; end
      d = DW'($urandom);
      if (i == 0) d[7:0] = head;
      send_beat(d, KW'($urandom), UW'($urandom), (i == len - 1));
    end
  endtask

  task automatic wait_idle();
    int n;
    bit empty;
    n = 0;
    empty = 1'b0;
    while (!empty && n < 3000) begin
      @(posedge clk); #1;
      n++;
      empty = 1'b1;
      for (int p = 0; p < NP; p++) if (exp_q[p].size() != 0) empty = 1'b0;
    end
    if (!empty) begin
      checks++; errors++;
      $display("FAIL drain_timeout got pending beats required none");
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  logic [7:0] heads [16] = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h02, 8'h42, 8'h04, 8'h45,
                              8'h1B, 8'h0A, 8'h4A, 8'h4B, 8'h30, 8'h74, 8'h1F, 8'h08};

  initial begin : main
    int b [NP];
    int v [NP];
    int idx, idxa, low_idx, d0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
    m_if.tready = '1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_tready", int'(s_if.tready[0]), 0);
    chk("reset_m_tvalid", int'(m_if.tvalid), 0);
    chk("reset_drop", int'(drop), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // MWr 3DW, 4 beats, all ready
    for (int p = 0; p < NP; p++) begin b[p] = pop_cnt[p]; v[p] = vld_cyc[p]; end
    idx = pop_cyc_q[2].size();
    send_pkt(8'h40, 4, 1'b0);
    wait_idle();
    chk("t1_port2_beats", pop_cnt[2] - b[2], 4);
    chk("t1_port0_vld", vld_cyc[0] - v[0], 0);
    chk("t1_port1_vld", vld_cyc[1] - v[1], 0);
    if (pop_cyc_q[2].size() > idx) chk("t1_latency", pop_cyc_q[2][idx] - last_head_cyc, 2);
    else chk("t1_latency", -1, 2);

    // CfgRd0 single beat followed by a 3-beat CplD
    for (int p = 0; p < NP; p++) b[p] = pop_cnt[p];
    idx  = pop_cyc_q[1].size();
    idxa = acc_cyc_q.size();
    send_pkt(8'h04, 1, 1'b0);
    send_pkt(8'h4A, 3, 1'b0);
    wait_idle();
    chk("t2_port0_beats", pop_cnt[0] - b[0], 1);
    chk("t2_port1_beats", pop_cnt[1] - b[1], 3);
    if (pop_cyc_q[1].size() >= idx + 3) chk("t2_out_no_bubble", pop_cyc_q[1][idx+2] - pop_cyc_q[1][idx], 2);
    else chk("t2_out_no_bubble", -1, 2);
    if (acc_cyc_q.size() >= idxa + 4) chk("t2_in_no_bubble", acc_cyc_q[idxa+3] - acc_cyc_q[idxa], 3);
    else chk("t2_in_no_bubble", -1, 3);

    // CplD stalled on port1 for 10 cycles mid-packet
    b[1] = pop_cnt[1];
    low_idx = 99;
    fork
      send_pkt(8'h4A, 8, 1'b0);
      begin
        int n;
        n = 0;
        while (pop_cnt[1] < b[1] + 2 && n < 200) begin @(posedge clk); #1; n++; end
        m_if.tready[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (!s_if.tready[0] && low_idx == 99) low_idx = i;
        end
        @(posedge clk); #1;
        m_if.tready[1] = 1'b1;
      end
    join
    wait_idle();
    chk("t3_tready_low_within_3", int'(low_idx <= 2), 1);
    chk("t3_port1_beats", pop_cnt[1] - b[1], 8);

    // Undefined type 0x1F, 3 beats, then an MRd to prove the FSM is idle again
    d0 = drop_seen;
    for (int p = 0; p < NP; p++) v[p] = vld_cyc[p];
    send_pkt(8'h1F, 3, 1'b0);
    wait_idle();
    chk("t4_drop_cycles", drop_seen - d0, 1);
    chk("t4_no_tvalid", (vld_cyc[0] - v[0]) + (vld_cyc[1] - v[1]) + (vld_cyc[2] - v[2]), 0);
    b[2] = pop_cnt[2];
    send_pkt(8'h00, 2, 1'b0);
    wait_idle();
    chk("t4_after_drop_port2", pop_cnt[2] - b[2], 2);

    // Randomized traffic with random back-pressure
    rdy_mode = 1;
    for (int n = 0; n < 120; n++) begin
      logic [7:0] h;
      h = ($urandom_range(3) == 0) ? 8'($urandom) : heads[$urandom_range(15)];
      send_pkt(h, int'($urandom_range(1, 6)), 1'($urandom));
    end
    rdy_mode = 0;
    @(posedge clk); #1;
    m_if.tready = '1;
    wait_idle();
    for (int p = 0; p < NP; p++) chk($sformatf("rand_left_port%0d", p), exp_q[p].size(), 0);
    chk("rand_drop_count", drop_seen, drop_exp);

    // Reset while beat 2 of a 5-beat MWr is on the input
    send_beat(32'hA5A5_0040, 4'hF, 1'b0, 1'b0);
    send_beat(32'h1111_2222, 4'hF, 1'b1, 1'b0);
    s_if.tvalid = 1'b1; s_if.tdata = 32'h3333_4444; s_if.tlast = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_m_tvalid", int'(m_if.tvalid), 0);
    chk("t6_rst_s_tready", int'(s_if.tready[0]), 0);
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    b[2] = pop_cnt[2];
    send_pkt(8'h00, 3, 1'b0);
    wait_idle();
    chk("t6_post_reset_port2", pop_cnt[2] - b[2], 3);

`ifdef PCIE_ROUTER_STATS_EN
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 5; n++) send_pkt(8'h0A, int'($urandom_range(1, 3)), 1'b0);
    for (int n = 0; n < 3; n++) send_pkt(8'h40, int'($urandom_range(1, 4)), 1'b0);
    wait_idle();
    chk("stat_port0", int'(stat_cnt[0*32 +: 32]), 0);
    chk("stat_port1", int'(stat_cnt[1*32 +: 32]), 5);
    chk("stat_port2", int'(stat_cnt[2*32 +: 32]), 3);
    for (int p = 0; p < NP; p++)
      chk($sformatf("stat_model_port%0d", p), int'(stat_cnt[p*32 +: 32]), exp_fwd_pkts[p]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
